// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter sharing one synchronous-read memory port among NUM_REQ requesters.
// Responses are buffered in a small FIFO; grants are credit-limited so the FIFO cannot overflow.
module mem_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 2,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
    } rsp_entry_t;

    logic [ID_W-1:0]       ptr;
    logic                  s1_valid;
    logic [ID_W-1:0]       s1_id;
    logic [ADDR_WIDTH-1:0] last_addr;

    rsp_entry_t            fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic                  pop;
    logic                  push;
    logic                  can_issue;
    logic                  grant;
    logic [ID_W-1:0]       winner;
    logic [ADDR_WIDTH-1:0] winner_addr;
    rsp_entry_t            head;

    function automatic logic [PTR_W-1:0] fifo_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == RSP_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [ID_W-1:0] req_inc(input logic [ID_W-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + ID_W'(1);
    endfunction

    assign pop  = rsp_valid && rsp_ready;
    assign push = s1_valid;

    // A credit freed by this cycle's pop may be spent by this cycle's grant.
    assign can_issue = (int'(fifo_count) + int'(s1_valid) - int'(pop)) < RSP_DEPTH;

    // NOTE: every variable gets a default at the top of an always_comb, so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        idx         = 0;
        grant       = 1'b0;
        winner      = '0;
        winner_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (can_issue && !grant && req_valid[idx]) begin
                grant       = 1'b1;
                winner      = ID_W'(idx);
                winner_addr = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    assign mem_addr = grant ? winner_addr : last_addr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            last_addr  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            s1_valid <= grant;
            if (grant) begin
                s1_id     <= winner;
                last_addr <= winner_addr;
                ptr       <= req_inc(winner);
            end
            if (push) wr_ptr <= fifo_inc(wr_ptr);
            if (pop)  rd_ptr <= fifo_inc(rd_ptr);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage has no reset; fifo_count alone decides what is valid, and outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{id: s1_id, data: mem_data};
    end

    assign head      = fifo_mem[rd_ptr];
    assign rsp_valid = (fifo_count != '0);
    assign rsp_id    = rsp_valid ? head.id   : '0;
    assign rsp_data  = rsp_valid ? head.data : '0;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: a round-robin reference model predicts grants and
// pushes expected responses into a scoreboard queue that a separate monitor drains and compares.
module tb_mem_read_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int RSP_DEPTH  = 2;
    localparam int ID_W       = 2;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_data = '0;
    logic                          rsp_valid;
    logic                          rsp_ready = 1'b0;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;

    mem_read_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] mem_f(input logic [ADDR_WIDTH-1:0] a);
        return 32'hA5A5_0000 | DATA_WIDTH'(a);
    endfunction

    // Synchronous-read memory: data for this cycle's address appears next cycle.
    always @(posedge clk) mem_data <= mem_f(mem_addr);

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
        int unsigned           rdy;
    } exp_t;
    exp_t exp_q[$];

    int                    m_ptr  = 0;
    logic [ADDR_WIDTH-1:0] m_last = '0;
    logic [NUM_REQ-1:0]    gnt_seen = '0;

    // Reference model: oldest unreturned read is visible two cycles after its grant; at most
    // RSP_DEPTH reads may be unreturned once this cycle's pop is taken into account.
    always @(negedge clk) begin
        int win;
        bit pop;
        int outstanding;
        logic [NUM_REQ-1:0]    exp_gnt;
        logic [ADDR_WIDTH-1:0] exp_addr;
        gnt_seen = req_ready;
        if (rst) begin
            exp_q.delete();
            m_ptr  = 0;
            m_last = '0;
        end else begin
            pop = 1'b0;
            if (exp_q.size() != 0)
                if (exp_q[0].rdy <= cyc && rsp_ready) pop = 1'b1;
            outstanding = exp_q.size() - int'(pop);
            win = -1;
            if (outstanding < RSP_DEPTH)
                for (int k = 0; k < NUM_REQ; k++)
                    if (win < 0 && req_valid[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
            exp_gnt  = '0;
            exp_addr = m_last;
            if (win >= 0) begin
                exp_gnt[win] = 1'b1;
                exp_addr     = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            end
            check("req_ready", 64'(req_ready), 64'(exp_gnt));
            check("mem_addr", 64'(mem_addr), 64'(exp_addr));
            if (dut.s1_valid)
                check("no_push_into_full_fifo",
                      64'(int'(dut.fifo_count) == RSP_DEPTH && !(rsp_valid && rsp_ready)), 64'(0));
            if (win >= 0) begin
                exp_q.push_back('{id: ID_W'(win), data: mem_f(exp_addr), rdy: cyc + 2});
                m_ptr  = (win + 1) % NUM_REQ;
                m_last = exp_addr;
            end
        end
    end

    // Monitor: compares the response stream against the scoreboard head.
    always begin
        bit exp_v;
        @(negedge clk);
        #1;
        if (!rst) begin
            exp_v = 1'b0;
            if (exp_q.size() != 0)
                if (exp_q[0].rdy <= cyc) exp_v = 1'b1;
            check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            if (exp_v) begin
                if (rsp_valid) begin
                    check("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                    check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
                end
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus. Ungranted requesters keep their request; the rest follow 'want'.
    task automatic cycle(input logic [NUM_REQ-1:0] want, input logic rr, input logic r,
                         input bit fix = 1'b0, input logic [ADDR_WIDTH-1:0] fa = '0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || gnt_seen[i]) begin
                req_valid[i] = want[i];
                req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = fix ? fa : ADDR_WIDTH'($urandom);
            end
        end
        rsp_ready = rr;
        rst       = r;
    endtask

    initial begin
        repeat (3) cycle('0, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b0);
        #3;
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
        check("reset_rsp_data", 64'(rsp_data), 64'(0));
        check("reset_mem_addr", 64'(mem_addr), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(0));

        // Single request from requester 2 at address 0x005, leaving ptr at 3.
        cycle(4'b0100, 1'b1, 1'b0, 1'b1, 12'h005);
        repeat (4) cycle('0, 1'b1, 1'b0);

        // Pointer skip: only requesters 1 and 3, expected 3,1,3,1.
        repeat (4) cycle(4'b1010, 1'b1, 1'b0);

        // Round robin with all requesters valid.
        repeat (12) cycle(4'b1111, 1'b1, 1'b0);

        // Idle: drain pending requests, then mem_addr must hold the last issued address.
        repeat (8) cycle('0, 1'b1, 1'b0);

        // Backpressure then release.
        repeat (10) cycle(4'b1111, 1'b0, 1'b0);
        repeat (8) cycle(4'b1111, 1'b1, 1'b0);
        repeat (8) cycle('0, 1'b1, 1'b0);

        // Reset with one response buffered and one read in flight.
        repeat (2) cycle(4'b1111, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1);
        repeat (4) cycle(4'b1111, 1'b1, 1'b0);
        repeat (8) cycle('0, 1'b1, 1'b0);

        // Randomized traffic, backpressure and occasional resets.
        for (int n = 0; n < 3000; n++)
            cycle(NUM_REQ'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 299) == 0));

        repeat (12) cycle('0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Round-robin read arbiter that shares one synchronous-read memory port (address in, registered data out one cycle later) among NUM_REQ requesters. It accepts per-requester read requests on valid/ready handshakes, drives the single memory address port, tracks the one-cycle in-flight read and returns each result on one response stream tagged with the requester index. A small response FIFO with credit-based issue control keeps responses in order and never drops them under `rsp_ready` backpressure.

## Interface
- NUM_REQ, 4: number of requesters, ≥2.
- ADDR_WIDTH, 12: memory address width.
- DATA_WIDTH, 32: memory data width.
- RSP_DEPTH, 2: response FIFO entries, ≥2.
- ID_W (localparam): max(1, $clog2(NUM_REQ)).

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flat; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  grant. At most one bit is high per cycle.
- mem_addr  out  ADDR_WIDTH  to the memory address input.
- mem_data  in  DATA_WIDTH  memory read data. It corresponds to the `mem_addr` of the previous cycle.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accepts.
- rsp_id  out  ID_W  index of the requester that owns `rsp_data`.
- rsp_data  out  DATA_WIDTH  read data.

## Operation
- **Request handshake:** a request from requester i transfers when req_valid[i] && req_ready[i] in the same cycle. Requesters hold `req_valid` and `req_addr` stable until granted.
- **Issue permission:** `can_issue` = (fifo_count + s1_valid − pop) < RSP_DEPTH, where pop = rsp_valid && rsp_ready.
- **Grant selection:** when `can_issue` is true, exactly one grant goes to the first valid requester at or after priority pointer `ptr`, searching upward modulo NUM_REQ. All other req_ready bits are 0. When `can_issue` is false, or no requester is valid, all req_ready bits are 0.
- **Pointer update:** after a grant to requester i, `ptr` becomes (i+1) mod NUM_REQ. With no grant, `ptr` holds.
- **Address path:** on a grant, `mem_addr` is the winner's address, combinationally. With no grant, `mem_addr` is `last_addr`, the register holding the most recently issued address.
- **In-flight stage:** on a grant, `s1_valid` is set to 1 and `s1_id` to the winner index for the next cycle. Otherwise `s1_valid` is cleared to 0.
- **FIFO push:** when s1_valid = 1, {s1_id, mem_data} is pushed into the response FIFO at the end of that cycle.
- **FIFO output:** `rsp_*` shows the FIFO head; rsp_valid = (fifo_count ≠ 0).
- **Simultaneous push and pop:** fifo_count is unchanged and the order is preserved.
- **Full FIFO:** a push into a full FIFO cannot occur because of the credit rule. The bench asserts this.
- **Ordering:** responses are delivered in grant order.
- **Reset values:**
  - `ptr` = 0, `s1_valid` = 0, `last_addr` = 0, FIFO empty.
  - Outputs: rsp_valid = 0, rsp_id = 0, rsp_data = 0, mem_addr = 0, req_ready = 0.
- **Reset mid-operation:** any in-flight read and all buffered responses are discarded. No response appears after reset releases unless a new grant occurs.

## Timing
- **Latency:** a grant in cycle t gives rsp_valid = 1 no earlier than cycle t+2, with mem_data sampled at the rising edge ending cycle t+1.
- **Throughput:** with rsp_ready held at 1, RSP_DEPTH = 2 sustains one grant per cycle.
- **Backpressure:** with rsp_ready = 0, at most RSP_DEPTH grants are outstanding (in flight plus buffered). Grants stop until a pop frees a credit, and the credit frees the same cycle as the pop.
- **Combinational paths:** `req_ready` and `mem_addr` depend combinationally on `req_valid`, `req_addr` and `rsp_ready`. There is no combinational path from `req_*` to `rsp_*`.
- **Response hold:** `rsp_*` holds stable while rsp_valid && !rsp_ready.

## Test plan
- **Single request:** reset, then req_valid[2] = 1 with addr 0x005 for one grant; memory model returns 0xA5A5_0005. Required: req_ready[2] = 1 in cycle t; rsp_valid = 1, rsp_id = 2, rsp_data = 0xA5A5_0005 at t+2; a single response only.
- **Round robin:** all four requesters valid continuously, rsp_ready = 1. Required: grant order 0,1,2,3,0,1…; one grant every cycle; rsp_id sequence matches the grant order.
- **Pointer skip:** ptr = 3 after a grant to 2; only requesters 1 and 3 valid. Required: grant to 3, then 1, then 3.
- **Backpressure:** all requesters valid, rsp_ready = 0 for 10 cycles, then 1. Required: exactly 2 grants, then none; FIFO never overflows; after release, responses drain in order and grants resume in the same cycle as the first pop.
- **Reset mid-operation:** assert rst for one cycle while one read is in flight and one response is buffered. Required: rsp_valid = 0 the cycle after reset; no stale response later; the next grant goes to the lowest-index valid requester (ptr = 0).
- **Idle:** a cycle with no valid requester. Required: req_ready = 0 and mem_addr holds the last issued address.
